pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Parametrised hazard, forwarding and flush controller for the in-order CPU pipeline. It sits beside the R (register-read) stage. It keeps a shadow pipeline of destination-register tags for every stage after R and drives stage enables, bubble insertion and per-operand forwarding selects. It generalises fixed X/M/W forwarding to configurable depth, register-address width and load latency, and adds taken-branch flush, memory-busy freeze and a stall-cycle counter.

## Interface
Parameters:
- RA_W, 3: register address width (SP included in the address space).
- DEPTH, 3: number of stages after R (stage 1 = X, 2 = M, 3 = W).
- LOAD_LAT, 1: extra stages before a load result is forwardable; legal range 1..DEPTH-1.
- SEL_W, $clog2(DEPTH+1): width of the forwarding selects.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- r_valid, in, 1: R stage holds a real instruction.
- r_src_a / r_src_b, in, RA_W each: source register addresses.
- r_use_a / r_use_b, in, 1 each: the source is actually read.
- r_dst, in, RA_W: destination register address.
- r_wr, in, 1: the instruction writes r_dst.
- r_load, in, 1: the instruction is a load or pop (result comes from memory).
- flush, in, 1: taken branch or jump resolved in X.
- mem_busy, in, 1: data memory not ready; the whole pipeline freezes.
- en_f, out, 1: enable for the F stage register.
- en_r, out, 1: enable for the R stage register.
- en_back, out, 1: enable for all stages after R.
- bubble_x, out, 1: X captures a NOP this cycle.
- flush_fr, out, 1: clear the F and R stage contents.
- fwd_a / fwd_b, out, SEL_W each: operand source. 0 = register file; k = stage k result.
- stall_cnt, out, 16: saturating count of hazard-stall cycles.

## Operation
- **Shadow state.** Entries sh[1..DEPTH], each {v, dst, load}.
- **Match rule.** Stage k matches source s when sh[k].v, sh[k].dst==s and use_s is set.
- **Youngest match.** For each source, only the match with the smallest k counts.
- **Forwardability.** A non-load entry is forwardable at any k≥1. A load entry is forwardable only at k>LOAD_LAT.
- **Hazard.** Raised when r_valid and either used source's youngest match is not forwardable.
- **Priority.** mem_busy > flush > hazard > normal.
- **mem_busy.** en_f=en_r=en_back=0, bubble_x=0, flush_fr=0. Shadow holds and stall_cnt holds. A flush raised during mem_busy is ignored; the requester holds flush until mem_busy drops.
- **flush.** en_f=en_r=en_back=1, flush_fr=1, bubble_x=1. sh[1] gets v=0, other entries shift, and the hazard is ignored.
- **hazard.** en_f=en_r=0, en_back=1, bubble_x=1. sh[1] gets v=0, other entries shift, and stall_cnt increments (it saturates at 0xFFFF).
- **normal.** All enables are 1 and bubble_x=0. sh[1] gets {r_valid&r_wr, r_dst, r_load} and other entries shift.
- **Shift.** sh[k+1] <= sh[k]; sh[DEPTH] retires. The register file is written at the end of stage DEPTH.
- **Forwarding selects.** fwd_a/fwd_b equal the youngest matching k, or 0 when there is no match or the source is unused. They are valid only when no hazard is raised.

## Timing
- All enables, selects and bubble/flush outputs are combinational from the shadow state and the current inputs. The shadow state and stall_cnt are registered.
- **Reset.** All sh[k].v=0 and stall_cnt=0. With inputs idle, outputs settle to en_f=en_r=en_back=1, bubble_x=0, flush_fr=0, fwd_a=fwd_b=0.
- **Reset mid-operation.** Discards all pending tags, so the next R instruction sees no hazard.
- **ALU to dependent instruction.** Zero stall cycles; fwd selects 1.
- **Load to dependent instruction.** Exactly LOAD_LAT stall cycles.
- **Without forwarding.** The dependent instruction stalls until the producer retires from stage DEPTH: DEPTH stall cycles when adjacent.

## Configuration
- **PIPE_FWD_EN defined:** forwarding as described above.
- **PIPE_FWD_EN undefined:**
  - Any match in stages 1..DEPTH is a hazard.
  - fwd_a and fwd_b are tied to 0.
  - Forwarding mux logic is removed.

## Test plan
- **Reset defaults.** Reset asserted 2 cycles with r_valid=1 -> all en=1, bubble_x=0, fwd=0, stall_cnt=0.
- **ALU chain.** ADD r1 then SUB reading r1 (PIPE_FWD_EN, DEPTH=3) -> no stall, fwd_a=1. The following instruction reading r1 -> fwd=2.
- **Load-use.** LD r2 then ADD reading r2 (LOAD_LAT=1) -> 1 cycle en_r=0, bubble_x=1, then fwd=2; stall_cnt=1.
- **Flush over hazard.** flush asserted in the same cycle as a load-use hazard -> flush_fr=1, en_r=1, stall_cnt unchanged.
- **Freeze.** mem_busy held 3 cycles during a load-use hazard -> all en=0, shadow and stall_cnt frozen; the hazard resumes after release.
- **No forwarding.** PIPE_FWD_EN undefined, ADD r3 then dependent instruction -> 3 stall cycles, fwd=0 throughout.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and flush controller that tracks destination tags for every stage after R.
// Define PIPE_FWD_EN to enable operand forwarding; without it any pending writer of a source stalls R.
module pipeline_hazard_unit #(
  parameter int RA_W     = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_valid,
  input  logic [RA_W-1:0]  r_src_a,
  input  logic [RA_W-1:0]  r_src_b,
  input  logic             r_use_a,
  input  logic             r_use_b,
  input  logic [RA_W-1:0]  r_dst,
  input  logic             r_wr,
  input  logic             r_load,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             en_f,
  output logic             en_r,
  output logic             en_back,
  output logic             bubble_x,
  output logic             flush_fr,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [15:0]      stall_cnt
);

  logic [DEPTH:1]  sh_v_reg;
  logic [DEPTH:1]  sh_ld_reg;
  logic [RA_W-1:0] sh_dst_reg [1:DEPTH];
  logic [15:0]     stall_cnt_reg;

  logic [DEPTH:1]  match_a;
  logic [DEPTH:1]  match_b;
  logic            block_a;
  logic            block_b;
  logic            hazard;
  logic            shift;
  logic            ins_v;
  logic            cnt_inc;

  for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
    assign match_a[gi] = sh_v_reg[gi] && (sh_dst_reg[gi] == r_src_a) && r_use_a;
    assign match_b[gi] = sh_v_reg[gi] && (sh_dst_reg[gi] == r_src_b) && r_use_b;
  end

`ifdef PIPE_FWD_EN
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             ld_a;
  logic             ld_b;

  // Scan oldest to youngest so the youngest (smallest k) match wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_a[k]) begin
        sel_a = SEL_W'(k);
        ld_a  = sh_ld_reg[k];
      end
      if (match_b[k]) begin
        sel_b = SEL_W'(k);
        ld_b  = sh_ld_reg[k];
      end
    end
  end

  // A load result only becomes forwardable once it has passed LOAD_LAT stages.
  assign block_a = (sel_a != '0) && ld_a && (sel_a <= SEL_W'(LOAD_LAT));
  assign block_b = (sel_b != '0) && ld_b && (sel_b <= SEL_W'(LOAD_LAT));
  assign fwd_a   = sel_a;
  assign fwd_b   = sel_b;
`else
  logic unused_ld;
  assign unused_ld = ^sh_ld_reg;
  assign block_a   = |match_a;
  assign block_b   = |match_b;
  assign fwd_a     = '0;
  assign fwd_b     = '0;
`endif

  assign hazard = r_valid && (block_a || block_b);

  // Priority: mem_busy freezes everything, flush overrides a hazard.
  always_comb begin
    en_f     = 1'b1;
    en_r     = 1'b1;
    en_back  = 1'b1;
    bubble_x = 1'b0;
    flush_fr = 1'b0;
    shift    = 1'b1;
    ins_v    = r_valid && r_wr;
    cnt_inc  = 1'b0;
    if (mem_busy) begin
      en_f    = 1'b0;
      en_r    = 1'b0;
      en_back = 1'b0;
      shift   = 1'b0;
      ins_v   = 1'b0;
    end else if (flush) begin
      flush_fr = 1'b1;
      bubble_x = 1'b1;
      ins_v    = 1'b0;
    end else if (hazard) begin
      en_f     = 1'b0;
      en_r     = 1'b0;
      bubble_x = 1'b1;
      ins_v    = 1'b0;
      cnt_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_v_reg      <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (shift) begin
        sh_v_reg[1]   <= ins_v;
        sh_dst_reg[1] <= r_dst;
        sh_ld_reg[1]  <= r_load;
        for (int k = 2; k <= DEPTH; k++) begin
          sh_v_reg[k]   <= sh_v_reg[k-1];
          sh_dst_reg[k] <= sh_dst_reg[k-1];
          sh_ld_reg[k]  <= sh_ld_reg[k-1];
        end
      end
      if (cnt_inc && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: a reference model pushes expected outputs per cycle,
// which are popped and compared at the falling edge.
module tb_pipeline_hazard_unit;
  localparam int RA_W     = 3;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = 2;
`ifdef PIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             r_valid;
  logic [RA_W-1:0]  r_src_a, r_src_b, r_dst;
  logic             r_use_a, r_use_b, r_wr, r_load;
  logic             flush, mem_busy;
  logic             en_f, en_r, en_back, bubble_x, flush_fr;
  logic [SEL_W-1:0] fwd_a, fwd_b;
  logic [15:0]      stall_cnt;

  pipeline_hazard_unit #(
    .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .r_valid(r_valid),
    .r_src_a(r_src_a), .r_src_b(r_src_b), .r_use_a(r_use_a), .r_use_b(r_use_b),
    .r_dst(r_dst), .r_wr(r_wr), .r_load(r_load), .flush(flush), .mem_busy(mem_busy),
    .en_f(en_f), .en_r(en_r), .en_back(en_back), .bubble_x(bubble_x), .flush_fr(flush_fr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ef, er, eb, bx, ff, hz;
    int fa, fb, sc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_no = 0;

  // Reference model of in-flight writers: index 1 is the youngest.
  bit   mv [1:DEPTH];
  int   md [1:DEPTH];
  bit   ml [1:DEPTH];
  int   mcnt;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc_no, got, want);
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= DEPTH; k++) mv[k] = 1'b0;
    mcnt = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; r_valid = 1'b1; r_wr = 1'b1; r_dst = 3'd1; r_load = 1'b1;
    r_src_a = 3'd1; r_src_b = 3'd1; r_use_a = 1'b1; r_use_b = 1'b1;
    flush = 1'b0; mem_busy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  // Find the youngest pending writer of src (0 when none or unused).
  function automatic int youngest(input int src, input bit use_s);
    int k0 = 0;
    for (int k = 1; k <= DEPTH; k++)
      if (k0 == 0 && use_s && mv[k] && md[k] == src) k0 = k;
    return k0;
  endfunction

  task automatic cyc(input bit v, input int a, input bit ua, input int b, input bit ub,
                     input int dst, input bit wr, input bit ld, input bit fl, input bit busy,
                     output bit accepted);
    exp_t e, g;
    int ka, kb;
    bit blk_a, blk_b;
    r_valid = v; r_src_a = a[RA_W-1:0]; r_src_b = b[RA_W-1:0];
    r_use_a = ua; r_use_b = ub; r_dst = dst[RA_W-1:0]; r_wr = wr; r_load = ld;
    flush = fl; mem_busy = busy; rst = 1'b0;

    ka = youngest(a, ua);
    kb = youngest(b, ub);
    if (FWD_ON) begin
      blk_a = (ka != 0) && ml[ka] && (ka <= LOAD_LAT);
      blk_b = (kb != 0) && ml[kb] && (kb <= LOAD_LAT);
      e.fa = ka; e.fb = kb;
    end else begin
      blk_a = (ka != 0);
      blk_b = (kb != 0);
      e.fa = 0; e.fb = 0;
    end
    e.hz = v && (blk_a || blk_b);
    e.sc = mcnt;
    if (busy) begin
      e.ef = 0; e.er = 0; e.eb = 0; e.bx = 0; e.ff = 0;
    end else if (fl) begin
      e.ef = 1; e.er = 1; e.eb = 1; e.bx = 1; e.ff = 1;
    end else if (e.hz) begin
      e.ef = 0; e.er = 0; e.eb = 1; e.bx = 1; e.ff = 0;
    end else begin
      e.ef = 1; e.er = 1; e.eb = 1; e.bx = 0; e.ff = 0;
    end
    exp_q.push_back(e);

    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
    end else begin
      g = exp_q.pop_front();
      check("en_f", en_f, g.ef);
      check("en_r", en_r, g.er);
      check("en_back", en_back, g.eb);
      check("bubble_x", bubble_x, g.bx);
      check("flush_fr", flush_fr, g.ff);
      check("stall_cnt", stall_cnt, g.sc);
      if (!g.hz || !FWD_ON) begin
        check("fwd_a", fwd_a, g.fa);
        check("fwd_b", fwd_b, g.fb);
      end
    end
    $display("cyc %0d v=%0b a=%0d/%0b b=%0d/%0b dst=%0d wr=%0b ld=%0b fl=%0b busy=%0b -> en_r=%0b bx=%0b fwd=%0d/%0d cnt=%0d",
             cyc_no, v, a, ua, b, ub, dst, wr, ld, fl, busy, en_r, bubble_x, fwd_a, fwd_b, stall_cnt);

    if (!busy) begin
      for (int k = DEPTH; k >= 2; k--) begin
        mv[k] = mv[k-1]; md[k] = md[k-1]; ml[k] = ml[k-1];
      end
      mv[1] = (!fl && !e.hz) ? (v && wr) : 1'b0;
      md[1] = dst; ml[1] = ld;
      if (!fl && e.hz && mcnt != 16'hFFFF) mcnt++;
    end
    accepted = !busy && (fl || !e.hz);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int a, input bit ua, input int b, input bit ub,
                       input int dst, input bit wr, input bit ld);
    bit done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) cyc(1, a, ua, b, ub, dst, wr, ld, 0, 0, done);
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask

  initial begin
    bit d;
    model_clear();
    do_reset(2);
    idle(2);                               // reset defaults

    issue(0, 0, 0, 0, 1, 1, 0);            // ADD r1
    issue(1, 1, 2, 1, 4, 1, 0);            // SUB r4 <- r1, r2
    issue(1, 1, 0, 0, 5, 1, 0);            // reads r1 again
    idle(4);

    issue(7, 1, 7, 1, 6, 1, 0);            // r6
    issue(0, 0, 6, 1, 7, 1, 0);            // operand b from r6
    idle(4);

    issue(0, 0, 0, 0, 2, 1, 1);            // LD r2
    issue(2, 1, 3, 1, 3, 1, 0);            // load-use
    idle(4);

    issue(0, 0, 0, 0, 3, 1, 1);            // LD r3
    cyc(1, 3, 1, 0, 0, 5, 1, 0, 1, 0, d);  // flush over load-use
    idle(4);

    issue(0, 0, 0, 0, 4, 1, 1);            // LD r4
    for (int i = 0; i < 3; i++) cyc(1, 4, 1, 0, 0, 6, 1, 0, 0, 1, d);
    issue(4, 1, 0, 0, 6, 1, 0);            // hazard resumes
    idle(4);

    issue(0, 0, 0, 0, 1, 1, 0);            // unused source does not match
    issue(1, 0, 1, 0, 2, 1, 0);
    idle(4);

    issue(0, 0, 0, 0, 5, 1, 1);            // LD r5 then reset mid-operation
    do_reset(1);
    issue(5, 1, 5, 1, 6, 1, 0);
    idle(4);

    for (int i = 0; i < 80; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
          $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, d);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
